// File: rtl/branch_target_predictor.sv
// +--------------------------------------------------------------------------+
// | branch_target_predictor: direct-mapped BTB with 2-bit counters, 1-cycle  |
// | lookup, write-first bypass of same-cycle updates.          Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module branch_target_predictor #(
  parameter int WORD_SIZE = 32,
  parameter int ENTRIES   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fetch_valid,
  input  logic [WORD_SIZE-1:0] fetch_pc,
  input  logic                 flush,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_taken,
  output logic                 pred_valid,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_pc,
  output logic [WORD_SIZE-1:0] pred_adder
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = WORD_SIZE - IDX_BITS - 2;

  logic                 valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  logic                 pred_valid_q;
  logic                 pred_hit_q;
  logic                 pred_taken_q;
  logic [WORD_SIZE-1:0] pred_pc_q;
  logic [WORD_SIZE-1:0] pred_adder_q;

  logic [IDX_BITS-1:0]  upd_idx;
  logic [TAG_BITS-1:0]  upd_tag;
  logic                 upd_hit;
  logic                 upd_we;
  logic [WORD_SIZE-1:0] new_target;
  logic [1:0]           new_ctr;
  logic [1:0]           unused_upd_lsb;

  assign upd_idx        = upd_pc[IDX_BITS+1:2];
  assign upd_tag        = upd_pc[WORD_SIZE-1:IDX_BITS+2];
  assign upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // Not-taken branches that miss never allocate, so they leave the table untouched.
  assign upd_we         = upd_valid && (upd_hit || upd_taken);
  assign unused_upd_lsb = upd_pc[1:0];

  always_comb begin
    new_target = upd_taken ? upd_target : target_q[upd_idx];
    new_ctr    = 2'b10;
    if (upd_hit) begin
      if (upd_taken) begin
        new_ctr = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
      end else begin
        new_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_we) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= new_target;
      ctr_q[upd_idx]    <= new_ctr;
    end
  end

  logic [IDX_BITS-1:0]  fetch_idx;
  logic [TAG_BITS-1:0]  fetch_tag;
  logic                 bypass;
  logic                 eff_valid;
  logic [TAG_BITS-1:0]  eff_tag;
  logic [WORD_SIZE-1:0] eff_target;
  logic [1:0]           eff_ctr;
  logic                 look_hit;
  logic                 look_taken;
  logic [WORD_SIZE-1:0] look_adder;
  logic [WORD_SIZE-1:0] look_pc;
  logic                 load_pred;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = fetch_pc[WORD_SIZE-1:IDX_BITS+2];

  // Write-first: a same-index update this cycle is visible to this lookup.
  assign bypass     = upd_we && (upd_idx == fetch_idx);
  assign eff_valid  = bypass ? 1'b1       : valid_q[fetch_idx];
  assign eff_tag    = bypass ? upd_tag    : tag_q[fetch_idx];
  assign eff_target = bypass ? new_target : target_q[fetch_idx];
  assign eff_ctr    = bypass ? new_ctr    : ctr_q[fetch_idx];

  assign look_hit   = eff_valid && (eff_tag == fetch_tag);
  assign look_taken = look_hit && eff_ctr[1];
  assign look_adder = fetch_pc + WORD_SIZE'(4);
  assign look_pc    = look_taken ? eff_target : look_adder;
  assign load_pred  = fetch_valid && !flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pred_valid_q <= 1'b0;
      pred_hit_q   <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_pc_q    <= '0;
      pred_adder_q <= '0;
    end else begin
      pred_valid_q <= load_pred;
      if (load_pred) begin
        pred_hit_q   <= look_hit;
        pred_taken_q <= look_taken;
        pred_pc_q    <= look_pc;
        pred_adder_q <= look_adder;
      end
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_hit   = pred_hit_q;
  assign pred_taken = pred_taken_q;
  assign pred_pc    = pred_pc_q;
  assign pred_adder = pred_adder_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// +--------------------------------------------------------------------------+
// | tb_branch_target_predictor: directed + random bench for the BTB.         |
// |                                                            Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_branch_target_predictor;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int IB = 4;

  logic         clk;
  logic         rstn;
  logic         fetch_valid;
  logic [W-1:0] fetch_pc;
  logic         flush;
  logic         upd_valid;
  logic [W-1:0] upd_pc;
  logic [W-1:0] upd_target;
  logic         upd_taken;
  logic         pred_valid;
  logic         pred_hit;
  logic         pred_taken;
  logic [W-1:0] pred_pc;
  logic [W-1:0] pred_adder;

  int checks   = 0;
  int failures = 0;

  branch_target_predictor #(.WORD_SIZE(W), .ENTRIES(N)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .flush       (flush),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .pred_valid  (pred_valid),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_pc     (pred_pc),
    .pred_adder  (pred_adder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table of entries indexed by (pc/4) mod N, tag = pc / (4*N).
  bit           m_valid  [N];
  int unsigned  m_tag    [N];
  logic [W-1:0] m_target [N];
  int           m_ctr    [N];
  logic         e_valid, e_hit, e_taken, e_known;
  logic [W-1:0] e_pc, e_adder;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_target[k] = '0; m_ctr[k] = 1;
      end
      e_valid = 0; e_hit = 0; e_taken = 0; e_pc = '0; e_adder = '0; e_known = 1;
    end else begin
      if (upd_valid) begin
        int unsigned ui, ut;
        ui = (upd_pc / 4) % N;
        ut = upd_pc / (4 * N);
        if (m_valid[ui] && m_tag[ui] == ut) begin
          if (upd_taken) begin
            m_ctr[ui]    = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
            m_target[ui] = upd_target;
          end else begin
            m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_valid[ui] = 1; m_tag[ui] = ut; m_target[ui] = upd_target; m_ctr[ui] = 2;
        end
      end
      if (fetch_valid && !flush) begin
        int unsigned fi, ft;
        fi      = (fetch_pc / 4) % N;
        ft      = fetch_pc / (4 * N);
        e_valid = 1;
        e_hit   = m_valid[fi] && m_tag[fi] == ft;
        e_taken = e_hit && m_ctr[fi] >= 2;
        e_adder = fetch_pc + 32'd4;
        e_pc    = e_taken ? m_target[fi] : e_adder;
        e_known = 1;
      end else begin
        e_valid = 0;
        // Held fields after a flushed lookup are not pinned down; skip them until reloaded.
        if (fetch_valid) e_known = 0;
      end
    end
    #1;
    chk("model_pred_valid", W'(pred_valid), W'(e_valid));
    if (e_known) begin
      chk("model_pred_hit",   W'(pred_hit),   W'(e_hit));
      chk("model_pred_taken", W'(pred_taken), W'(e_taken));
      chk("model_pred_pc",    pred_pc,        e_pc);
      chk("model_pred_adder", pred_adder,     e_adder);
    end
  end

  task automatic step(input logic fv, input logic [W-1:0] fpc, input logic fl,
                      input logic uv, input logic [W-1:0] upc, input logic [W-1:0] utg,
                      input logic utk);
    fetch_valid = fv; fetch_pc = fpc; flush = fl;
    upd_valid = uv; upd_pc = upc; upd_target = utg; upd_taken = utk;
    @(negedge clk);
  endtask

  task automatic lookup(input logic [W-1:0] pc);
    step(1'b1, pc, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic update(input logic [W-1:0] pc, input logic [W-1:0] tgt, input logic tk);
    step(1'b0, '0, 1'b0, 1'b1, pc, tgt, tk);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_pc();
    logic [W-1:0] tag;
    tag = W'($urandom_range(0, 2));
    if (tag == 2) tag = 32'h03FF_FFFF;
    return (tag << 6) | (W'($urandom_range(0, 15)) << 2) | W'($urandom_range(0, 3));
  endfunction

  initial begin
    rstn = 1'b0;
    fetch_valid = 0; fetch_pc = '0; flush = 0;
    upd_valid = 0; upd_pc = '0; upd_target = '0; upd_taken = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_valid", W'(pred_valid), 0);
    chk("reset_pc",    pred_pc,        0);
    rstn = 1'b1;

    lookup(32'h100);
    chk("cold_valid", W'(pred_valid), 1);
    chk("cold_hit",   W'(pred_hit),   0);
    chk("cold_taken", W'(pred_taken), 0);
    chk("cold_pc",    pred_pc,        32'h104);
    chk("cold_adder", pred_adder,     32'h104);

    update(32'h100, 32'h200, 1'b1);
    lookup(32'h100);
    chk("alloc_hit",   W'(pred_hit),   1);
    chk("alloc_taken", W'(pred_taken), 1);
    chk("alloc_pc",    pred_pc,        32'h200);

    update(32'h100, 32'h0, 1'b0);
    update(32'h100, 32'h0, 1'b0);
    lookup(32'h100);
    chk("nt2_hit",   W'(pred_hit),   1);
    chk("nt2_taken", W'(pred_taken), 0);
    chk("nt2_pc",    pred_pc,        32'h104);
    update(32'h100, 32'h0, 1'b0);
    lookup(32'h100);
    chk("sat0_taken", W'(pred_taken), 0);
    update(32'h100, 32'h0, 1'b1);
    lookup(32'h100);
    chk("sat0_up_taken", W'(pred_taken), 0);

    pulse_reset();
    update(32'h100, 32'h200, 1'b1);
    update(32'h140, 32'h300, 1'b1);
    lookup(32'h100);
    chk("alias_old_hit", W'(pred_hit), 0);
    chk("alias_old_pc",  pred_pc,      32'h104);
    lookup(32'h140);
    chk("alias_new_hit", W'(pred_hit), 1);
    chk("alias_new_pc",  pred_pc,      32'h300);

    pulse_reset();
    step(1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 32'h400, 1'b1);
    chk("bypass_hit", W'(pred_hit), 1);
    chk("bypass_pc",  pred_pc,      32'h400);

    step(1'b1, 32'h100, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("flush_valid", W'(pred_valid), 0);

    lookup(32'hFFFF_FFFC);
    chk("wrap_adder", pred_adder, 32'h0);
    chk("wrap_pc",    pred_pc,    32'h0);

    lookup(32'h100);
    fetch_valid = 1; fetch_pc = 32'h100;
    upd_valid = 1; upd_pc = 32'h100; upd_target = 32'h500; upd_taken = 1;
    rstn = 1'b0;
    #1;
    chk("midrst_valid", W'(pred_valid), 0);
    chk("midrst_hit",   W'(pred_hit),   0);
    chk("midrst_pc",    pred_pc,        0);
    chk("midrst_adder", pred_adder,     0);
    @(negedge clk);
    rstn = 1'b1;
    lookup(32'h100);
    chk("postrst_hit", W'(pred_hit), 0);

    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] fpc, upc;
      fpc = rand_pc();
      upc = ($urandom_range(0, 3) == 0) ? fpc : rand_pc();
      step(($urandom_range(0, 9) < 7), fpc, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), upc, W'($urandom) & 32'hFFFF_FFFC,
           ($urandom_range(0, 9) < 6));
      if (n == 1500) pulse_reset();
    end

    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
